wb_mem_responder: RTL and testbench

//  Memory-side responder for the waterbear core: serves instruction fetches and

---
 rtl/wb_mem_responder.sv | 129 ++++++++++++
 tb/tb_wb_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_responder.sv
// wb_mem_responder: word-addressed program/data RAM behind a valid/ready
// request/response handshake, one transaction outstanding at a time.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. Outputs
// are held stable while valid is high and the partner has not yet taken them.
module wb_mem_responder #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("wb_mem_responder: RD_LATENCY must be in 1..4");
    end

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    // WAIT holds RD_LATENCY-1 cycles; counter runs down to zero before RESP.
    localparam logic [1:0]      CNT_INIT  = 2'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [1:0]          cnt;
    logic [DATA_W-1:0]   data_q;
    logic                err_q;
    logic                accept;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign in_range = ({1'b0, req_addr} < DEPTH_LIM);
    assign idx      = req_addr[IDX_W-1:0];

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs; req_ready is forced low during reset.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst;
                accept    = req_valid && rst;
                if (accept) begin
                    state_nx = (RD_LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt == 2'd0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Response payload is captured at accept so it stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= 2'd0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            cnt   <= CNT_INIT;
            err_q <= !in_range;
            if (!in_range) begin
                data_q <= '0;
            end else if (req_we) begin
                data_q <= req_wdata;
            end else begin
                data_q <= mem[idx];
            end
        end else if (state == WAIT && cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
        end
    end

    // RAM write at the accept edge; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (accept && req_we && in_range) begin
            mem[idx] <= req_wdata;
        end
    end

    assign rsp_rdata = rsp_valid ? data_q : '0;
    assign rsp_err   = rsp_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: instance a (latency 1, 256 words) and
// instance b (latency 3, 128 words) share request/response lines.
module tb_wb_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid_a;
    logic        req_valid_b;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_ready;
    logic        req_ready_a, req_ready_b;
    logic        rsp_valid_a, rsp_valid_b;
    logic [15:0] rsp_rdata_a, rsp_rdata_b;
    logic        rsp_err_a, rsp_err_b;
    logic        busy_a, busy_b;

    logic        sel;
    logic        cur_ready, cur_valid, cur_err, cur_busy;
    logic [15:0] cur_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];
    logic [15:0] model_a [256];
    logic [15:0] model_b [128];

    wb_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .RD_LATENCY(1)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a),
        .rsp_err(rsp_err_a), .busy(busy_a)
    );

    wb_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(128), .RD_LATENCY(3)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b),
        .rsp_err(rsp_err_b), .busy(busy_b)
    );

    assign cur_ready = sel ? req_ready_b : req_ready_a;
    assign cur_valid = sel ? rsp_valid_b : rsp_valid_a;
    assign cur_err   = sel ? rsp_err_b   : rsp_err_a;
    assign cur_busy  = sel ? busy_b      : busy_a;
    assign cur_rdata = sel ? rsp_rdata_b : rsp_rdata_a;

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {31'd0, cur_valid}, 32'd0);
        check({tag, "_ready"}, {31'd0, cur_ready}, 32'd1);
        check({tag, "_busy"},  {31'd0, cur_busy},  32'd0);
        check({tag, "_out"},   {15'd0, cur_err, cur_rdata}, 32'd0);
    endtask

    // One full transaction on instance s; bp = cycles of rsp_ready low.
    task automatic run_req(input logic s, input logic we, input logic [7:0] addr,
                           input logic [15:0] wdata, input int bp);
        logic [16:0] e;
        int          lat;
        int          exp_lat;
        int          depth;
        sel     = s;
        depth   = s ? 128 : 256;
        exp_lat = s ? 3 : 1;
        @(negedge clk);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = (bp == 0);
        if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        check("req_ready_idle", {31'd0, cur_ready}, 32'd1);
        if (int'(addr) >= depth) begin
            e = {1'b1, 16'h0000};
        end else if (we) begin
            if (s) model_b[addr[6:0]] = wdata; else model_a[addr] = wdata;
            e = {1'b0, wdata};
        end else begin
            e = {1'b0, s ? model_b[addr[6:0]] : model_a[addr]};
        end
        exp_q.push_back(e);
        @(negedge clk);
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        lat = 1;
        while (!cur_valid && lat < 10) begin
            check("busy_wait",  {31'd0, cur_busy},  32'd1);
            check("ready_wait", {31'd0, cur_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        if (cur_valid) begin
            e = exp_q.pop_front();
            check("rsp_data", {15'd0, cur_err, cur_rdata}, {15'd0, e});
            check("busy_resp", {31'd0, cur_busy}, 32'd1);
            for (int i = 0; i < bp; i++) begin
                if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
                @(negedge clk);
                check("bp_valid", {31'd0, cur_valid}, 32'd1);
                check("bp_data",  {15'd0, cur_err, cur_rdata}, {15'd0, e});
                check("bp_ready", {31'd0, cur_ready}, 32'd0);
            end
            req_valid_a = 1'b0;
            req_valid_b = 1'b0;
            rsp_ready   = 1'b1;
            @(negedge clk);
            check_idle("post_rsp");
        end
    endtask

    initial begin
        logic [7:0]  a8;
        logic [15:0] d16;
        logic        w;
        rst = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_we = 1'b0;
        req_addr = 8'h00;
        req_wdata = 16'h0000;
        rsp_ready = 1'b0;
        sel = 1'b0;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready_a", {31'd0, req_ready_a}, 32'd0);
        check("rst_ready_b", {31'd0, req_ready_b}, 32'd0);
        check("rst_valid_a", {31'd0, rsp_valid_a}, 32'd0);
        check("rst_valid_b", {31'd0, rsp_valid_b}, 32'd0);
        check("rst_busy_a",  {31'd0, busy_a}, 32'd0);
        check("rst_busy_b",  {31'd0, busy_b}, 32'd0);
        check("rst_out_a",   {15'd0, rsp_err_a, rsp_rdata_a}, 32'd0);
        rst = 1'b1;
        #1;
        check("rel_ready_a", {31'd0, req_ready_a}, 32'd1);
        check("rel_ready_b", {31'd0, req_ready_b}, 32'd1);

        // Latency 1: store then load
        run_req(1'b0, 1'b1, 8'h0D, 16'h00C5, 0);
        run_req(1'b0, 1'b0, 8'h0D, 16'h0000, 0);

        // Latency 1: preload a window, then random loads/stores inside it
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, 1'b1, 8'h30 + 8'(i), 16'($urandom_range(0, 65535)), 0);
        end
        for (int i = 0; i < 8; i++) begin
            w   = 1'($urandom_range(0, 1));
            a8  = 8'h30 + 8'($urandom_range(0, 3));
            d16 = 16'($urandom_range(0, 65535));
            run_req(1'b0, w, a8, d16, int'($urandom_range(0, 2)));
        end

        // Latency 3: store then load
        run_req(1'b1, 1'b1, 8'h07, 16'h0380, 0);
        run_req(1'b1, 1'b0, 8'h07, 16'h0000, 0);

        // Backpressure five cycles with ignored requests
        run_req(1'b1, 1'b0, 8'h07, 16'h0000, 5);

        // Out of range on 128-word instance must not alias onto 0x48
        run_req(1'b1, 1'b1, 8'h48, 16'h5A5A, 0);
        run_req(1'b1, 1'b1, 8'hC8, 16'hFFFF, 0);
        run_req(1'b1, 1'b0, 8'h48, 16'h0000, 0);
        run_req(1'b1, 1'b0, 8'hFF, 16'h0000, 2);

        // Reset in WAIT after an accepted store
        sel = 1'b1;
        @(negedge clk);
        req_we = 1'b1;
        req_addr = 8'h10;
        req_wdata = 16'h1234;
        req_valid_b = 1'b1;
        rsp_ready = 1'b1;
        model_b[7'h10] = 16'h1234;
        @(negedge clk);
        req_valid_b = 1'b0;
        check("t6_busy_wait", {31'd0, busy_b}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid0", {31'd0, rsp_valid_b}, 32'd0);
        @(negedge clk);
        check("t6_valid1", {31'd0, rsp_valid_b}, 32'd0);
        check("t6_busy",   {31'd0, busy_b}, 32'd0);
        check("t6_ready",  {31'd0, req_ready_b}, 32'd0);
        rst = 1'b1;
        run_req(1'b1, 1'b0, 8'h10, 16'h0000, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
